alu_op_sequencer: RTL
=====================

# alu_op_sequencer

Command front-end for the 4-bit ALU tile. It accepts {opcode, a, b} commands over a valid/ready interface and buffers them in a small FIFO. It drives the ALU's `ui_in`/`uio_in` pins one command at a time, captures the registered ALU result and flags, and presents them on a valid/ready response port. It sits directly upstream of the ALU and also consumes the ALU outputs.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  single clock for this block and the ALU.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept; equals (`fifo_count` < `DEPTH`).
- `cmd_opcode`  in  4  ALU opcode.
- `cmd_a`  in  4  operand a.
- `cmd_b`  in  4  operand b.
- `alu_ui_in`  out  8  to ALU `ui_in`; carries {a, b}.
- `alu_uio_in`  out  8  to ALU `uio_in`; carries {4'b0, opcode}.
- `alu_rst_n`  out  1  to ALU `rst_n`; combinational `~rst`.
- `alu_uo_out`  in  8  ALU result.
- `alu_uio_out`  in  8  ALU flags: [7] overflow, [6] carry.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  8  captured ALU result.
- `rsp_carry`  out  1  captured carry, masked as described under Operation.
- `rsp_overflow`  out  1  captured overflow, masked as described under Operation.
- `rsp_opcode`  out  4  opcode of the response.
- `fifo_count`  out  $clog2(DEPTH)+1  queued entries; excludes the in-flight command.

## Operation
- FIFO:
  - Push on `cmd_valid & cmd_ready`.
  - Pop is internal, issued by the FSM.
  - Push and pop in the same cycle leaves the count unchanged.
  - No bypass: an entry pushed into an empty FIFO is poppable the following cycle.
  - Pointers wrap modulo `DEPTH`.
  - When full, `cmd_ready`=0, even if a pop occurs in the same cycle.
- Operand registers:
  - `alu_ui_in` and `alu_uio_in` are registered. They load only on pop and hold their value otherwise.
- FSM states are IDLE, ISSUE, CAPTURE, HOLD.
  - IDLE: if FIFO not empty, pop and go to ISSUE.
  - ISSUE: ALU sees stable operands and registers its result at the end of this cycle. Go to CAPTURE.
  - CAPTURE: latch `alu_uo_out` into `rsp_result`, and the masked flags and opcode into the other response fields. Set `rsp_valid`. Go to HOLD.
  - HOLD: response fields are frozen while `rsp_valid`=1 and `rsp_ready`=0. On handshake, clear `rsp_valid`. If the FIFO is not empty, pop in the same cycle and go to ISSUE; otherwise go to IDLE.
- Flag masking:
  - `rsp_carry` = `alu_uio_out[6]` and `rsp_overflow` = `alu_uio_out[7]` only when opcode is 4'b0000 (ADD) or 4'b0001 (SUB). Otherwise both are 0, because the ALU retains stale flags for other opcodes.
- Result handling:
  - `rsp_result` is passed through unmodified for all opcodes, including undefined opcodes ≥ 4'b1011, which the ALU returns as 0x00.
- Ordering: responses are delivered strictly in command order, with at most one command in flight.

## Timing
- Reset (`rst`=1 at a rising edge):
  - FIFO emptied; `fifo_count`=0; `cmd_ready`=1 from the first cycle after reset.
  - State becomes IDLE.
  - `rsp_valid`, `rsp_result`, `rsp_carry`, `rsp_overflow`, `rsp_opcode` = 0.
  - `alu_ui_in` and `alu_uio_in` = 0x00.
  - `alu_rst_n`=0 while `rst`=1.
- Reset mid-operation: any in-flight or queued command is dropped without a response. A pending `rsp_valid` is cleared on the reset edge.
- Latency: a command accepted at edge E0 into an idle, empty block gives `rsp_valid`=1 after edge E3.
- Throughput: with `rsp_ready` held at 1, one response every 3 cycles (ISSUE, CAPTURE, HOLD).
- A `cmd_valid` deassertion without handshake is legal; nothing is pushed.

## Test plan
- ADD a=9, b=8 -> `rsp_result`=0x01, `rsp_carry`=1, `rsp_overflow`=1, `rsp_valid` 3 cycles after acceptance.
- SUB a=3, b=5 -> 0x0E, carry=0, overflow=0.
- Flag masking: ADD 9+8 immediately followed by MUL a=F, b=F -> second response 0xE1 with carry=0, overflow=0.
- Mixed ops in order: DIV a=7, b=2, then ENC a=1, b=2, then SLT a=2, b=3, then opcode 4'b1111 -> 0x13, 0xB9, 0x01, 0x00, returned in that order.
- Back-pressure with `rsp_ready`=0: offer 6 back-to-back commands.
  - Exactly 5 are accepted (1 in flight, 4 queued); `fifo_count`=4; `cmd_ready`=0.
  - Then hold `rsp_ready`=1: 5 in-order responses spaced 3 cycles apart, and `cmd_ready` returns to 1 after the first pop.
- Reset mid-op: assert `rst` for 1 cycle during CAPTURE with 2 commands queued.
  - No response appears; all outputs read 0 and `fifo_count`=0.
  - A new ADD 1+1 afterwards returns 0x02.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Command front-end for the 4-bit ALU tile. It queues {opcode, a, b} commands
// in a small FIFO and issues one at a time to the ALU. It then captures the
// registered ALU result and masked flags, and presents them on a valid/ready
// response port.
module alu_op_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_opcode,
  input  logic [3:0]               cmd_a,
  input  logic [3:0]               cmd_b,
  output logic [7:0]               alu_ui_in,
  output logic [7:0]               alu_uio_in,
  output logic                     alu_rst_n,
  input  logic [7:0]               alu_uo_out,
  input  logic [7:0]               alu_uio_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_result,
  output logic                     rsp_carry,
  output logic                     rsp_overflow,
  output logic [3:0]               rsp_opcode,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture,
    StHold
  } state_t;

  // FIFO entry layout: {opcode, a, b}
  logic [11:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  state_t        r_state;
  state_t        w_state_next;

  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_capture;
  logic          w_rsp_clear;
  logic          w_flag_en;
  logic [11:0]   w_head;

  logic [7:0]    r_ui_in;
  logic [7:0]    r_uio_in;
  logic          r_rsp_valid;
  logic [7:0]    r_rsp_result;
  logic          r_rsp_carry;
  logic          r_rsp_overflow;
  logic [3:0]    r_rsp_opcode;

  // Only the overflow and carry flag bits are meaningful to this block.
  logic          w_unused_flags;
  assign w_unused_flags = ^alu_uio_out[5:0];

  assign w_empty   = (r_count == '0);
  assign cmd_ready = (r_count < FullCount);
  assign w_push    = cmd_valid & cmd_ready;
  assign w_head    = r_mem[r_rptr];

  // Command FIFO storage; no reset needed since the count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {cmd_opcode, cmd_a, cmd_b};
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state and control strobes.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_rsp_clear  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        w_state_next = StCapture;
      end
      StCapture: begin
        w_capture    = 1'b1;
        w_state_next = StHold;
      end
      StHold: begin
        if (rsp_ready) begin
          w_rsp_clear = 1'b1;
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = StIssue;
          end else begin
            w_state_next = StIdle;
          end
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Operand registers driving the ALU; updated only when a command is popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ui_in  <= 8'h00;
      r_uio_in <= 8'h00;
    end else if (w_pop) begin
      r_ui_in  <= w_head[7:0];
      r_uio_in <= {4'b0000, w_head[11:8]};
    end
  end

  // Flags are only refreshed by the ALU for ADD and SUB.
  assign w_flag_en = (r_uio_in[3:0] == 4'b0000) || (r_uio_in[3:0] == 4'b0001);

  // Response capture; fields stay frozen until the next capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid    <= 1'b0;
      r_rsp_result   <= 8'h00;
      r_rsp_carry    <= 1'b0;
      r_rsp_overflow <= 1'b0;
      r_rsp_opcode   <= 4'h0;
    end else if (w_capture) begin
      r_rsp_valid    <= 1'b1;
      r_rsp_result   <= alu_uo_out;
      r_rsp_carry    <= alu_uio_out[6] & w_flag_en;
      r_rsp_overflow <= alu_uio_out[7] & w_flag_en;
      r_rsp_opcode   <= r_uio_in[3:0];
    end else if (w_rsp_clear) begin
      r_rsp_valid    <= 1'b0;
    end
  end

  assign alu_ui_in    = r_ui_in;
  assign alu_uio_in   = r_uio_in;
  assign alu_rst_n    = ~rst;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_result   = r_rsp_result;
  assign rsp_carry    = r_rsp_carry;
  assign rsp_overflow = r_rsp_overflow;
  assign rsp_opcode   = r_rsp_opcode;
  assign fifo_count   = r_count;

endmodule
